// File: rtl/ddr_line_fetch_if.sv
// ddr_line_fetch_if: AXI-style read address/data channel between the line fetcher (master) and DDR (slave)
interface ddr_line_fetch_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 256
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0] arlen;
  logic arvalid;
  logic arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic rvalid;
  logic rlast;
  logic rready;
  modport master (output araddr, arlen, arvalid, rready, input arready, rdata, rvalid, rlast);
  modport slave (input araddr, arlen, arvalid, rready, output arready, rdata, rvalid, rlast);
endinterface

// File: rtl/ddr_line_fetch.sv
// ddr_line_fetch: fetches one display line per request from a ping-pong DDR frame buffer as fixed read bursts into the read buffer
// Optional DDR_FETCH_RLAST_CHECK_EN adds a sticky err_proto flag for rlast/beat-count disagreement
module ddr_line_fetch #(
  parameter int DQ_WIDTH = 32,
  parameter int H_WIDTH = 1280,
  parameter int H_HEIGHT = 720,
  parameter int BURST_LEN = 16,
  parameter int ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE0 = 28'h000_0000,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE1 = 28'h020_0000
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  input  logic frame_instruct,
  input  logic line_req,
  ddr_line_fetch_if.master axi,
  output logic buf_wr_en,
  output logic [DQ_WIDTH*8-1:0] buf_wr_data,
  output logic line_done,
  output logic busy,
  output logic err_overrun
`ifdef DDR_FETCH_RLAST_CHECK_EN
  , output logic err_proto
`endif
);
  localparam int BEATS_PER_LINE = H_WIDTH * 16 / (DQ_WIDTH * 8);
  localparam int BURSTS_PER_LINE = BEATS_PER_LINE / BURST_LEN;
  localparam int BURST_BYTES = BURST_LEN * DQ_WIDTH;
  localparam int LINE_BYTES = BEATS_PER_LINE * DQ_WIDTH;
  localparam int LW = $clog2(H_HEIGHT);
  localparam int BW = $clog2(BURSTS_PER_LINE);
  localparam int CW = $clog2(BURST_LEN);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;

  state_t state;
  logic [LW-1:0] line_idx;
  logic [BW-1:0] burst_idx;
  logic [CW-1:0] beat_cnt;
  logic [ADDR_WIDTH-1:0] base;
  logic pending;
  logic abort;
  logic acc;
  logic last;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] b, input logic [LW-1:0] l,
                                                    input logic [BW-1:0] k);
    return b + ADDR_WIDTH'(l) * ADDR_WIDTH'(LINE_BYTES) + ADDR_WIDTH'(k) * ADDR_WIDTH'(BURST_BYTES);
  endfunction

  assign axi.arlen = 8'(BURST_LEN - 1);
  assign acc = axi.rvalid && axi.rready;
  assign last = beat_cnt == CW'(BURST_LEN - 1);
  assign busy = state != IDLE;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      line_idx <= '0;
      burst_idx <= '0;
      beat_cnt <= '0;
      base <= FRAME_BASE0;
      pending <= 1'b0;
      abort <= 1'b0;
      axi.araddr <= '0;
      axi.arvalid <= 1'b0;
      axi.rready <= 1'b0;
      buf_wr_en <= 1'b0;
      buf_wr_data <= '0;
      line_done <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      buf_wr_en <= 1'b0;
      line_done <= 1'b0;
      if (line_req && busy && !frame_start) begin
        if (pending) err_overrun <= 1'b1;
        pending <= 1'b1;
      end
      case (state)
        IDLE: if (!frame_start && (line_req || pending)) begin
          state <= ADDR;
          axi.arvalid <= 1'b1;
          axi.araddr <= addr_of(base, line_idx, '0);
          pending <= line_req && pending;
        end
        // An address already on the bus must complete its handshake even when the frame restarts
        ADDR: if (axi.arready) begin
          axi.arvalid <= 1'b0;
          axi.rready <= 1'b1;
          beat_cnt <= '0;
          abort <= 1'b0;
          state <= (abort || frame_start) ? DRAIN : DATA;
        end else if (frame_start) abort <= 1'b1;
        DATA: begin
          if (frame_start) state <= DRAIN;
          if (acc) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (!frame_start) begin
              buf_wr_en <= 1'b1;
              buf_wr_data <= axi.rdata;
            end
            if (last) begin
              beat_cnt <= '0;
              axi.rready <= 1'b0;
              if (frame_start) state <= IDLE;
              else if (burst_idx < BW'(BURSTS_PER_LINE - 1)) begin
                burst_idx <= burst_idx + 1'b1;
                state <= ADDR;
                axi.arvalid <= 1'b1;
                axi.araddr <= addr_of(base, line_idx, burst_idx + 1'b1);
              end else begin
                state <= DONE;
                line_done <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          burst_idx <= '0;
          line_idx <= (line_idx == LW'(H_HEIGHT - 1)) ? '0 : line_idx + 1'b1;
          state <= IDLE;
        end
        DRAIN: if (acc) begin
          beat_cnt <= last ? '0 : beat_cnt + 1'b1;
          if (last) begin
            axi.rready <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (frame_start) begin
        base <= frame_instruct ? FRAME_BASE1 : FRAME_BASE0;
        line_idx <= '0;
        burst_idx <= '0;
        pending <= 1'b0;
        err_overrun <= 1'b0;
      end
    end

`ifdef DDR_FETCH_RLAST_CHECK_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) err_proto <= 1'b0;
    else if (acc && (axi.rlast != last)) err_proto <= 1'b1;
`endif
endmodule

// File: tb/tb_ddr_line_fetch.sv
// tb_ddr_line_fetch: directed bench for ddr_line_fetch with a small DDR read-channel model
module tb_ddr_line_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic frame_instruct = 1'b0;
  logic line_req = 1'b0;
  logic buf_wr_en;
  logic [255:0] buf_wr_data;
  logic line_done;
  logic busy;
  logic err_overrun;

  ddr_line_fetch_if #(.ADDR_WIDTH(28), .DATA_WIDTH(256)) axi ();

  ddr_line_fetch dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .frame_instruct(frame_instruct),
    .line_req(line_req),
    .axi(axi),
    .buf_wr_en(buf_wr_en),
    .buf_wr_data(buf_wr_data),
    .line_done(line_done),
    .busy(busy),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  logic [27:0] ar_q[$];
  logic [27:0] ar_log[$];
  logic [255:0] wr_q[$];
  int beat = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int stop_at = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit stop_en = 1'b0;
  bit rv_toggle = 1'b0;
  bit ph = 1'b0;
  bit ar_en = 1'b1;

  assign axi.arready = ar_en;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DDR model: queue accepted addresses, return 16 beats per burst tagged {addr, beat}
  always @(posedge clk)
    if (rst) begin
      ar_q.delete();
      beat = 0;
    end else begin
      if (axi.rvalid && axi.rready) begin
        acc_cnt++;
        if (beat == 15) begin
          beat = 0;
          void'(ar_q.pop_front());
        end else beat++;
      end
      if (axi.arvalid && axi.arready) begin
        ar_q.push_back(axi.araddr);
        ar_log.push_back(axi.araddr);
      end
    end

  always @(negedge clk) begin
    ph = !ph;
    if (ar_q.size() > 0 && !(stop_en && acc_cnt == stop_at) && (!rv_toggle || ph)) begin
      axi.rvalid = 1'b1;
      axi.rdata = {8{ar_q[0], 4'(beat)}};
      axi.rlast = beat == 15;
    end else begin
      axi.rvalid = 1'b0;
      axi.rdata = '0;
      axi.rlast = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (buf_wr_en) wr_q.push_back(buf_wr_data);
    if (line_done) begin
      done_cnt++;
      check("done_with_wr", buf_wr_en, 1'b1);
    end
    if (axi.arvalid) check("arlen", axi.arlen, 8'd15);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req();
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
  endtask

  task automatic pulse_fs(input bit sel);
    frame_instruct = sel;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    check("line_done_seen", done_cnt > d0, 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && busy; i++) @(negedge clk);
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic verify_line(input logic [27:0] a, input string tag, input int d0);
    int bad;
    logic [27:0] ea;
    logic [3:0] eb;
    wait_done(d0);
    tick(3);
    check({tag, "_ndone"}, done_cnt, d0 + 1);
    check({tag, "_nar"}, ar_log.size(), 5);
    for (int k = 0; k < ar_log.size() && k < 5; k++) check({tag, "_araddr"}, ar_log[k], a + 28'(k * 512));
    check({tag, "_nwr"}, wr_q.size(), 80);
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++) begin
      ea = a + 28'((i / 16) * 512);
      eb = 4'(i % 16);
      if (wr_q[i] !== {8{ea, eb}}) bad++;
    end
    check({tag, "_data"}, bad, 0);
  endtask

  task automatic run_line(input logic [27:0] a, input string tag);
    int d0;
    wr_q.delete();
    ar_log.delete();
    d0 = done_cnt;
    pulse_req();
    verify_line(a, tag, d0);
  endtask

  initial begin
    int d0;
    tick(3);
    check("rst_busy", busy, 1'b0);
    check("rst_arvalid", axi.arvalid, 1'b0);
    check("rst_rready", axi.rready, 1'b0);
    check("rst_wr_en", buf_wr_en, 1'b0);
    check("rst_line_done", line_done, 1'b0);
    check("rst_overrun", err_overrun, 1'b0);
    rst = 1'b0;
    tick(2);

    pulse_fs(1'b0);
    run_line(28'h000_0000, "l0");
    run_line(28'h000_0A00, "l1");
    for (int l = 2; l < 720; l++) begin
      d0 = done_cnt;
      ar_log.delete();
      wr_q.delete();
      pulse_req();
      wait_done(d0);
      if (l == 719) check("l719_araddr", ar_log.size() > 0 ? ar_log[0] : 28'hFFF_FFFF, 28'(719 * 2560));
      tick(1);
    end
    tick(2);
    run_line(28'h000_0000, "wrap");

    pulse_fs(1'b1);
    run_line(28'h020_0000, "fb1");

    ar_en = 1'b0;
    wr_q.delete();
    ar_log.delete();
    d0 = done_cnt;
    pulse_req();
    for (int i = 0; i < 10; i++) begin
      check("bp_arvalid", axi.arvalid, 1'b1);
      check("bp_araddr", axi.araddr, 28'h020_0A00);
      tick(1);
    end
    ar_en = 1'b1;
    rv_toggle = 1'b1;
    verify_line(28'h020_0A00, "bp", d0);
    rv_toggle = 1'b0;

    acc_cnt = 0;
    stop_at = 39;
    stop_en = 1'b1;
    wr_q.delete();
    ar_log.delete();
    pulse_req();
    for (int i = 0; i < 500 && acc_cnt < 39; i++) @(negedge clk);
    tick(2);
    check("ab_wr_before", wr_q.size(), 39);
    pulse_fs(1'b0);
    stop_en = 1'b0;
    tick(3);
    check("ab_drain_rready", axi.rready, 1'b1);
    check("ab_drain_busy", busy, 1'b1);
    wait_idle();
    tick(2);
    check("ab_beats", acc_cnt, 48);
    check("ab_wr_after", wr_q.size(), 39);
    check("ab_nar", ar_log.size(), 3);
    check("ab_rready", axi.rready, 1'b0);
    run_line(28'h000_0000, "ab_next");

    ar_en = 1'b0;
    acc_cnt = 0;
    wr_q.delete();
    ar_log.delete();
    pulse_req();
    tick(3);
    pulse_fs(1'b1);
    tick(2);
    check("aa_arvalid", axi.arvalid, 1'b1);
    check("aa_araddr", axi.araddr, 28'h000_0A00);
    ar_en = 1'b1;
    wait_idle();
    check("aa_beats", acc_cnt, 16);
    check("aa_wr", wr_q.size(), 0);
    check("aa_nar", ar_log.size(), 1);
    run_line(28'h020_0000, "aa_next");

    pulse_fs(1'b0);
    tick(1);
    d0 = done_cnt;
    ar_log.delete();
    pulse_req();
    tick(5);
    pulse_req();
    tick(5);
    check("ovr_pending_only", err_overrun, 1'b0);
    pulse_req();
    tick(1);
    check("ovr_set", err_overrun, 1'b1);
    wait_done(d0);
    tick(2);
    check("ovr_next_arvalid", axi.arvalid, 1'b1);
    check("ovr_next_araddr", axi.araddr, 28'h000_0A00);
    wait_done(d0 + 1);
    tick(5);
    check("ovr_idle", busy, 1'b0);
    check("ovr_ndone", done_cnt, d0 + 2);
    check("ovr_nar", ar_log.size(), 10);
    check("ovr_sticky", err_overrun, 1'b1);
    pulse_fs(1'b0);
    check("ovr_cleared", err_overrun, 1'b0);

    pulse_fs(1'b1);
    wr_q.delete();
    pulse_req();
    tick(2);
    pulse_req();
    pulse_req();
    check("mr_overrun", err_overrun, 1'b1);
    for (int i = 0; i < 500 && wr_q.size() < 20; i++) @(negedge clk);
    check("mr_midburst", busy, 1'b1);
    rst = 1'b1;
    tick(1);
    check("mr_busy", busy, 1'b0);
    check("mr_arvalid", axi.arvalid, 1'b0);
    check("mr_araddr", axi.araddr, 28'h0);
    check("mr_rready", axi.rready, 1'b0);
    check("mr_wr_en", buf_wr_en, 1'b0);
    check("mr_line_done", line_done, 1'b0);
    check("mr_overrun_clr", err_overrun, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(2);
    run_line(28'h000_0000, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ddr_line_fetch.md
Name: ddr_line_fetch

Overview:
- Upstream feeder of the HDMI read-buffer stage.
- On each display line request, fetches one 1280-pixel RGB565 line from DDR over an AXI-style read channel, as fixed-length bursts.
- Forwards every returned beat as buf_wr_en/buf_wr_data into the read buffer.
- Frame base address selects between two DDR frame buffers (ping-pong), driven by frame_instruct.

Parameters:
- DQ_WIDTH, 32, DDR DQ width; data bus is DQ_WIDTH*8 bits (256).
- H_WIDTH, 1280, pixels per line.
- H_HEIGHT, 720, lines per frame.
- BURST_LEN, 16, beats per read burst.
- ADDR_WIDTH, 28, byte-address width.
- FRAME_BASE0, 28'h000_0000, byte base of buffer 0.
- FRAME_BASE1, 28'h020_0000, byte base of buffer 1.

Derived constants:
- BEATS_PER_LINE = H_WIDTH*16/(DQ_WIDTH*8) = 80.
- BURSTS_PER_LINE = BEATS_PER_LINE/BURST_LEN = 5.
- BURST_BYTES = BURST_LEN*DQ_WIDTH = 512.
- LINE_BYTES = BEATS_PER_LINE*DQ_WIDTH = 2560.

Ports:
- clk  in  1  system/DDR user clock.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at display vsync rising edge.
- frame_instruct  in  1  buffer select, sampled on frame_start (0 = FRAME_BASE0).
- line_req  in  1  one-cycle pulse requesting the next line.
- axi_araddr  out  ADDR_WIDTH  burst byte address.
- axi_arlen  out  8  constant BURST_LEN-1.
- axi_arvalid  out  1  address valid.
- axi_arready  in  1  address accepted.
- axi_rdata  in  DQ_WIDTH*8  read data.
- axi_rvalid  in  1  read data valid.
- axi_rlast  in  1  last beat of burst.
- axi_rready  out  1  read data accept.
- buf_wr_en  out  1  write strobe to the read buffer.
- buf_wr_data  out  DQ_WIDTH*8  write data to the read buffer.
- line_done  out  1  one-cycle pulse when a line is complete.
- busy  out  1  FSM not in IDLE.
- err_overrun  out  1  sticky; cleared on frame_start.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; line_idx, burst_idx, beat_cnt, pending = 0; base = FRAME_BASE0.
- FSM states: IDLE, ADDR, DATA, DONE, DRAIN.
- IDLE: go to ADDR on (line_req | pending), then clear pending.
- ADDR:
  - axi_arvalid=1; axi_araddr = base + line_idx*LINE_BYTES + burst_idx*BURST_BYTES.
  - Address and valid held stable until axi_arready.
  - On handshake: arvalid drops next cycle, go to DATA.
- DATA:
  - axi_rready=1.
  - Each accepted beat (rvalid&rready) produces buf_wr_en=1 and buf_wr_data=rdata exactly 1 cycle later (registered).
  - beat_cnt counts 0..BURST_LEN-1; the burst ends on the beat where beat_cnt==BURST_LEN-1.
  - Burst end with burst_idx<BURSTS_PER_LINE-1: burst_idx++, go to ADDR.
  - Otherwise go to DONE.
- DONE (1 cycle):
  - line_done=1, coincident with the last buf_wr_en.
  - burst_idx=0.
  - line_idx++, wrapping from H_HEIGHT-1 to 0.
  - Go to IDLE.
- line_req while busy:
  - If pending==0, set pending=1.
  - If pending==1, drop the request and set err_overrun=1.
- frame_start (priority over line_req in the same cycle):
  - Latch base from frame_instruct; line_idx=0; burst_idx=0; pending=0; err_overrun=0.
  - In IDLE/DONE: return to IDLE.
  - In ADDR: keep arvalid until handshake (no AXI protocol violation), then go to DRAIN with beat_cnt=0.
  - In DATA: go to DRAIN, keeping beat_cnt.
- DRAIN:
  - axi_rready=1; beats are consumed but not forwarded (buf_wr_en stays 0).
  - When the burst count completes, go to IDLE.
  - A line_req seen during DRAIN sets pending.
- Address arithmetic is modulo 2^ADDR_WIDTH.
- axi_rvalid outside DATA/DRAIN is ignored; axi_rready=0 there.

Optional Feature:
- Macro: DDR_FETCH_RLAST_CHECK_EN.
- With the macro defined:
  - Adds output err_proto (sticky, cleared only by rst).
  - err_proto is set when axi_rlast disagrees with beat_cnt==BURST_LEN-1 on any accepted beat.
  - Burst termination still follows beat_cnt.
- Without it: axi_rlast is unused; no err_proto port.

Test Plan:
- Reset: assert rst mid-burst → next cycle all outputs 0, busy=0; after release, the next line_req issues araddr=0x0.
- Basic line fetch (arready and rvalid always 1): frame_start with frame_instruct=0, then line_req → five ARs at 0x000, 0x200, 0x400, 0x600, 0x800, each with arlen=15; 80 buf_wr_en pulses with data matching rdata 1 cycle delayed; single line_done.
- Line stepping and buffer select:
  - Second line_req → first araddr 0xA00.
  - After 720 lines, line_idx wraps to 0.
  - New frame_start with frame_instruct=1 → first araddr 0x020_0000.
- Backpressure: arready held 0 for 10 cycles → arvalid=1 and araddr stable throughout. rvalid toggling 1/0 → still exactly 80 writes per line, no duplicates.
- Abort mid-burst: frame_start after 7 beats of burst 2 → no further buf_wr_en, rready stays 1 for the 9 remaining beats, then IDLE with line_idx=0. Next line_req reads the new base.
- Overrun: two line_req pulses during a fetch → the second is served immediately after line_done; a third raises err_overrun=1, which clears on the next frame_start.
